// File: rtl/local_ni_if.sv
// Local-port bundle between the network interface and its environment:
// core tx/rx handshakes plus the router's L port.
interface local_ni_if #(parameter int DATASIZE = 40);
  logic                tx_valid;
  logic                tx_ready;
  logic [3:0]          tx_dst;
  logic [21:0]         tx_data;
  logic [1:0]          tx_type;
  logic [DATASIZE-1:0] L_data_in;
  logic                L_valid_in;
  logic                full;
  logic [DATASIZE-1:0] L_data_out;
  logic                L_valid_out;
  logic                rx_valid;
  logic [3:0]          rx_src;
  logic [21:0]         rx_data;
  logic [1:0]          rx_type;
  logic [7:0]          rx_latency;
  logic                rx_misroute;

  modport slave (
    input  tx_valid, tx_dst, tx_data, tx_type, full, L_data_out, L_valid_out,
    output tx_ready, L_data_in, L_valid_in,
           rx_valid, rx_src, rx_data, rx_type, rx_latency, rx_misroute
  );

  modport master (
    output tx_valid, tx_dst, tx_data, tx_type, full, L_data_out, L_valid_out,
    input  tx_ready, L_data_in, L_valid_in,
           rx_valid, rx_src, rx_data, rx_type, rx_latency, rx_misroute
  );
endinterface

// File: rtl/local_ni.sv
// Local network interface: stamps and queues core packets toward the router L port,
// registers ejected flits, measures latency and keeps saturating statistics.
module local_ni #(
  parameter int         DATASIZE = 40,
  parameter logic [3:0] NODE_ID  = 4'd0,
  parameter int         Q_DEPTH  = 4,
  parameter int         QW       = 2,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  local_ni_if.slave        ni,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count
);
  typedef logic [DATASIZE-1:0] flit_t;
  localparam logic [QW:0] FULL_CNT = (QW+1)'(Q_DEPTH);

  flit_t            mem_q [Q_DEPTH];
  flit_t            mem_d [Q_DEPTH];
  logic [QW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [QW:0]      cnt_q, cnt_d;
  logic [7:0]       ts_q, ts_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, err_cnt_q, err_cnt_d;

  logic             rx_valid_q, rx_valid_d, rx_mis_q, rx_mis_d;
  logic [3:0]       rx_src_q, rx_src_d;
  logic [21:0]      rx_data_q, rx_data_d;
  logic [1:0]       rx_type_q, rx_type_d;
  logic [7:0]       rx_lat_q, rx_lat_d;

  logic q_full, q_empty, push, pop, mis;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Full/empty come from registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  assign q_full  = (cnt_q == FULL_CNT);
  assign q_empty = (cnt_q == '0);
  assign push    = ni.tx_valid && !q_full;
  assign pop     = !q_empty && !ni.full;
  assign mis     = (ni.L_data_out[DATASIZE-5 -: 4] != NODE_ID);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ts_d  = ts_q + 8'd1;
    // Popped slots are zeroed so an empty queue presents an all-zero head.
    if (pop) begin
      mem_d[rd_q] = '0;
      rd_d        = rd_q + QW'(1);
    end
    if (push) begin
      mem_d[wr_q] = {NODE_ID, ni.tx_dst, ts_q, ni.tx_data, ni.tx_type};
      wr_d        = wr_q + QW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (QW+1)'(1);
      2'b01:   cnt_d = cnt_q - (QW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rx_valid_d = ni.L_valid_out;
    rx_src_d   = rx_src_q;
    rx_data_d  = rx_data_q;
    rx_type_d  = rx_type_q;
    rx_lat_d   = rx_lat_q;
    rx_mis_d   = rx_mis_q;
    if (ni.L_valid_out) begin
      rx_src_d  = ni.L_data_out[DATASIZE-1 -: 4];
      rx_data_d = ni.L_data_out[23:2];
      rx_type_d = ni.L_data_out[1:0];
      rx_lat_d  = ts_q - ni.L_data_out[DATASIZE-9 -: 8];
      rx_mis_d  = mis;
    end
    tx_cnt_d  = sat_inc(tx_cnt_q, pop);
    rx_cnt_d  = sat_inc(rx_cnt_q, ni.L_valid_out);
    err_cnt_d = sat_inc(err_cnt_q, ni.L_valid_out && mis);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Q_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ts_q       <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_src_q   <= '0;
      rx_data_q  <= '0;
      rx_type_q  <= '0;
      rx_lat_q   <= '0;
      rx_mis_q   <= 1'b0;
    end else begin
      for (int i = 0; i < Q_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      ts_q       <= ts_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      err_cnt_q  <= err_cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_src_q   <= rx_src_d;
      rx_data_q  <= rx_data_d;
      rx_type_q  <= rx_type_d;
      rx_lat_q   <= rx_lat_d;
      rx_mis_q   <= rx_mis_d;
    end
  end

  assign ni.tx_ready    = !q_full;
  assign ni.L_valid_in  = pop;
  assign ni.L_data_in   = mem_q[rd_q];
  assign ni.rx_valid    = rx_valid_q;
  assign ni.rx_src      = rx_src_q;
  assign ni.rx_data     = rx_data_q;
  assign ni.rx_type     = rx_type_q;
  assign ni.rx_latency  = rx_lat_q;
  assign ni.rx_misroute = rx_mis_q;
  assign tx_count       = tx_cnt_q;
  assign rx_count       = rx_cnt_q;
  assign err_count      = err_cnt_q;
endmodule

// File: tb/tb_local_ni.sv
// Scoreboard bench for local_ni: stimulus pushes expected flits/ejects into queues,
// a negedge monitor pops and compares against what the DUT presents.
module tb_local_ni;
  localparam int         DS    = 40;
  localparam logic [3:0] NID   = 4'd0;
  localparam int         CNT_W = 4;

  typedef struct {
    logic [3:0]  src;
    logic [21:0] data;
    logic [1:0]  typ;
    logic [7:0]  lat;
    logic        mis;
  } rx_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] tx_count, rx_count, err_count;

  local_ni_if #(.DATASIZE(DS)) bus ();

  local_ni #(.DATASIZE(DS), .NODE_ID(NID), .Q_DEPTH(4), .QW(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ni(bus),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference timestamp, mirrors the free-running 8-bit clock of the node.
  logic [7:0] tb_ts;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 8'd1;

  logic [DS-1:0]    exp_tx[$];
  rx_t              exp_rx[$];
  rx_t              e;
  logic [CNT_W-1:0] m_tx, m_rx, m_err;
  int               sz;
  logic             pop_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_tx.delete();
      exp_rx.delete();
      m_tx = '0; m_rx = '0; m_err = '0;
    end else begin
      sz    = exp_tx.size();
      pop_e = (sz != 0) && !bus.full;
      chk("tx_ready", bus.tx_ready, sz < 4);
      chk("L_valid_in", bus.L_valid_in, pop_e);
      chk("tx_count", tx_count, m_tx);
      if (pop_e) begin
        if (bus.L_valid_in) chk("L_data_in", bus.L_data_in, exp_tx[0]);
        void'(exp_tx.pop_front());
        if (m_tx != '1) m_tx = m_tx + 1'b1;
      end
      if (bus.tx_valid && sz < 4)
        exp_tx.push_back({NID, bus.tx_dst, tb_ts, bus.tx_data, bus.tx_type});

      chk("rx_valid", bus.rx_valid, exp_rx.size() != 0);
      chk("rx_count", rx_count, m_rx);
      chk("err_count", err_count, m_err);
      if (exp_rx.size() != 0) begin
        e = exp_rx.pop_front();
        if (bus.rx_valid) begin
          chk("rx_src", bus.rx_src, e.src);
          chk("rx_data", bus.rx_data, e.data);
          chk("rx_type", bus.rx_type, e.typ);
          chk("rx_latency", bus.rx_latency, e.lat);
          chk("rx_misroute", bus.rx_misroute, e.mis);
        end
      end
      if (bus.L_valid_out) begin
        e.src  = bus.L_data_out[39:36];
        e.mis  = bus.L_data_out[35:32] != NID;
        e.lat  = tb_ts - bus.L_data_out[31:24];
        e.data = bus.L_data_out[23:2];
        e.typ  = bus.L_data_out[1:0];
        exp_rx.push_back(e);
        if (m_rx != '1) m_rx = m_rx + 1'b1;
        if (e.mis && m_err != '1) m_err = m_err + 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [DS-1:0] fl;
  int            sent;
  logic          acc;

  initial begin
    bus.tx_valid = 0; bus.tx_dst = '0; bus.tx_data = '0; bus.tx_type = '0;
    bus.full = 0; bus.L_valid_out = 0; bus.L_data_out = '0;
    repeat (2) cyc();
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_L_valid_in", bus.L_valid_in, 0);
    chk("rst_L_data_in", bus.L_data_in, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_counts", {tx_count, rx_count, err_count}, 0);
    rst_n = 1;

    // Test 1 + 4: push at ts=3, eject ts=250 flit at ts=4.
    for (int i = 0; i < 300 && tb_ts != 8'd3; i++) cyc();
    chk("ts_wait", tb_ts, 3);
    bus.tx_valid = 1; bus.tx_dst = 4'd5; bus.tx_data = 22'h1234; bus.tx_type = 2'd1;
    cyc();
    bus.tx_valid = 0;
    fl = {NID, 4'd5, 8'd3, 22'h1234, 2'd1};
    chk("t1_L_valid_in", bus.L_valid_in, 1);
    chk("t1_L_data_in", bus.L_data_in, fl);
    bus.L_valid_out = 1; bus.L_data_out = {4'd7, NID, 8'd250, 22'h2AB, 2'd2};
    cyc();
    bus.L_valid_out = 0;
    chk("t1_tx_count", tx_count, 1);
    chk("t4_rx_valid", bus.rx_valid, 1);
    chk("t4_rx_latency", bus.rx_latency, 10);
    chk("t4_rx_misroute", bus.rx_misroute, 0);
    chk("t4_rx_count", rx_count, 1);

    // Test 5: misrouted flit followed back-to-back by a good one.
    bus.L_valid_out = 1; bus.L_data_out = {4'd9, 4'd3, 8'd0, 22'h3FFFFF, 2'd3};
    cyc();
    bus.L_data_out = {4'd2, NID, 8'd255, 22'h00001, 2'd0};
    chk("t5_rx_misroute", bus.rx_misroute, 1);
    cyc();
    bus.L_valid_out = 0;
    chk("t5_rx_valid2", bus.rx_valid, 1);
    chk("t5_rx_misroute2", bus.rx_misroute, 0);
    chk("t5_err_count", err_count, 1);
    chk("t5_rx_count", rx_count, 3);
    cyc();

    // Test 2: fill behind a full router, then drain in order.
    bus.full = 1;
    for (int i = 0; i < 4; i++) begin
      bus.tx_valid = 1; bus.tx_dst = 4'(i + 1); bus.tx_data = 22'(16'hA0 + i); bus.tx_type = 2'(i);
      cyc();
    end
    bus.tx_valid = 0;
    chk("t2_tx_ready", bus.tx_ready, 0);
    chk("t2_L_valid_in", bus.L_valid_in, 0);
    bus.full = 0;
    repeat (5) cyc();

    // Test 3: pop from a full queue while tx_valid stays high, then random traffic.
    bus.full = 1; bus.tx_valid = 1;
    repeat (5) cyc();
    bus.full = 0;
    #1;
    chk("t3_full_ready", bus.tx_ready, 0);
    chk("t3_full_pop", bus.L_valid_in, 1);
    sent = 0;
    for (int i = 0; i < 2000 && sent < 100; i++) begin
      bus.tx_valid = ($urandom_range(7) != 0);
      bus.tx_dst   = 4'($urandom);
      bus.tx_data  = 22'($urandom);
      bus.tx_type  = 2'($urandom);
      bus.full     = ($urandom_range(3) == 0);
      bus.L_valid_out = ($urandom_range(3) == 0);
      bus.L_data_out  = DS'({$urandom, $urandom});
      #1;
      acc = bus.tx_valid && bus.tx_ready;
      cyc();
      if (acc) sent++;
    end
    chk("t3_sent", sent, 100);
    bus.tx_valid = 0; bus.full = 0; bus.L_valid_out = 0;
    repeat (8) cyc();
    chk("t3_drained", exp_tx.size(), 0);

    // Test 6: async reset with 3 flits queued.
    bus.full = 1;
    for (int i = 0; i < 3; i++) begin
      bus.tx_valid = 1; bus.tx_data = 22'(i + 5);
      cyc();
    end
    bus.tx_valid = 0;
    bus.full = 0;
    #1;
    rst_n = 0;
    #1;
    chk("t6_L_valid_in", bus.L_valid_in, 0);
    chk("t6_L_data_in", bus.L_data_in, 0);
    chk("t6_tx_ready", bus.tx_ready, 1);
    chk("t6_counts", {tx_count, rx_count, err_count}, 0);
    cyc();
    rst_n = 1;
    repeat (6) cyc();
    chk("t6_no_stale_tx", tx_count, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
